debounce: RTL and testbench

DEBOUNCE -- requirements
Module: debounce

---
 rtl/debounce.sv | 80 ++++++++
 tb/tb_debounce.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce.sv
// Switch debouncer: 2-flop synchronizer, free-running 2^N tick, 8-state FSM.
// db changes only after sw_s2 holds a new level across three ticks.
module debounce #(
  parameter int N = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db
);

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    WAIT1_1 = 3'd1,
    WAIT1_2 = 3'd2,
    WAIT1_3 = 3'd3,
    ONE     = 3'd4,
    WAIT0_1 = 3'd5,
    WAIT0_2 = 3'd6,
    WAIT0_3 = 3'd7
  } state_t;

  logic         sw_s1_q, sw_s1_d;
  logic         sw_s2_q, sw_s2_d;
  logic [N-1:0] q_q, q_d;
  state_t       state_q, state_d;
  logic         db_q, db_d;
  logic         tick;

  assign tick = (q_q == '0);

  always_comb begin
    sw_s1_d = sw;
    sw_s2_d = sw_s1_q;
    q_d     = q_q + {{(N-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ZERO:    if (sw_s2_q) state_d = WAIT1_1;
      WAIT1_1: if (!sw_s2_q) state_d = ZERO; else if (tick) state_d = WAIT1_2;
      WAIT1_2: if (!sw_s2_q) state_d = ZERO; else if (tick) state_d = WAIT1_3;
      WAIT1_3: if (!sw_s2_q) state_d = ZERO; else if (tick) state_d = ONE;
      ONE:     if (!sw_s2_q) state_d = WAIT0_1;
      WAIT0_1: if (sw_s2_q) state_d = ONE; else if (tick) state_d = WAIT0_2;
      WAIT0_2: if (sw_s2_q) state_d = ONE; else if (tick) state_d = WAIT0_3;
      WAIT0_3: if (sw_s2_q) state_d = ONE; else if (tick) state_d = ZERO;
      default: state_d = ZERO;
    endcase
  end

  // db is flopped from the next state so it always mirrors the state register.
  always_comb begin
    db_d = 1'b0;
    case (state_d)
      ONE, WAIT0_1, WAIT0_2, WAIT0_3: db_d = 1'b1;
      default:                        db_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1_q <= 1'b0;
      sw_s2_q <= 1'b0;
      q_q     <= '0;
      state_q <= ZERO;
      db_q    <= 1'b0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      q_q     <= q_d;
      state_q <= state_d;
      db_q    <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: tb/tb_debounce.sv
// Directed and random bench for debounce with N=3 against a run-length reference model.
module tb_debounce;

  logic clk = 1'b0;
  logic reset;
  logic sw;
  logic db;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic m_s1, m_s2, m_db;
  int   m_edge, m_run, m_ticks;

  // latency tracking relative to a marked instant
  int   since_mark;
  int   chg_at;
  logic db_prev;

  debounce #(.N(3)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .db    (db)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0;
    m_edge = 0; m_run = 0; m_ticks = 0;
  endtask

  // db flips once the synchronized level has disagreed with db on consecutive
  // edges and three tick edges have passed after the first disagreeing edge.
  task automatic model_edge();
    logic tk;
    tk = ((m_edge % 8) == 0);
    if (m_s2 == m_db) begin
      m_run = 0; m_ticks = 0;
    end else begin
      if (m_run > 0 && tk) m_ticks++;
      m_run++;
      if (m_ticks == 3) begin
        m_db = ~m_db; m_run = 0; m_ticks = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = sw;
    m_edge++;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    n_chk++;
    assert (val >= lo && val <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic mark();
    since_mark = 0;
    chg_at     = -1;
    db_prev    = db;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check("db_vs_model", db, m_db);
    since_mark++;
    if (db !== db_prev && chg_at < 0) chg_at = since_mark;
    db_prev = db;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called just after a step (edge + 1): reset lands mid-cycle.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check(tag, db, 1'b0);
    hold(3);
    #3;
    reset = 1'b0;
    mark();
  endtask

  task automatic glitch_half();
    sw = ~sw;
    #4;
    sw = ~sw;
    step();
  endtask

  task automatic glitch_clk();
    sw = ~sw;
    step();
    sw = ~sw;
  endtask

  initial begin
    sw    = 1'b0;
    reset = 1'b1;
    model_reset();
    mark();
    #1;
    check("reset_db", db, 1'b0);
    hold(3);
    #3;
    reset = 1'b0;
    hold(10);

    // bounce then settle low
    mark();
    for (int i = 0; i < 16; i++) begin
      sw = ~sw;
      step();
    end
    sw = 1'b0;
    hold(30);
    check("bounce_no_change", (chg_at < 0), 1'b1);

    // clean rise
    mark();
    sw = 1'b1;
    hold(40);
    check_range("rise_latency", chg_at, 18, 27);
    check("rise_db", db, 1'b1);

    // short low dip aborts
    mark();
    sw = 1'b0;
    hold(10);
    sw = 1'b1;
    hold(30);
    check("dip_no_change", (chg_at < 0), 1'b1);

    // clean fall
    mark();
    sw = 1'b0;
    hold(40);
    check_range("fall_latency", chg_at, 18, 27);
    check("fall_db", db, 1'b0);

    // glitches in ZERO
    mark();
    glitch_clk();
    hold(20);
    glitch_half();
    hold(10);
    check("glitch_zero", (chg_at < 0), 1'b1);

    // go to ONE, glitches in ONE
    sw = 1'b1;
    hold(40);
    mark();
    glitch_clk();
    hold(20);
    glitch_half();
    hold(10);
    check("glitch_one", (chg_at < 0), 1'b1);
    check("glitch_one_db", db, 1'b1);

    // reset while in ONE, sw stays high
    async_reset("reset_in_one");
    hold(40);
    check_range("relatch_after_one", chg_at, 18, 27);

    // reset while in WAIT1_3: 20 edges after release with sw high
    async_reset("reset_prep");
    hold(20);
    check("wait1_3_db_low", db, 1'b0);
    async_reset("reset_in_wait1_3");
    hold(40);
    check_range("relatch_after_wait", chg_at, 18, 27);

    // random segments: stable levels and bursts of bounce
    for (int s = 0; s < 40; s++) begin
      int len;
      len = int'($urandom_range(1, 45));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < len; i++) begin
          sw = 1'($urandom);
          step();
        end
      end else begin
        sw = 1'($urandom);
        hold(len);
      end
    end
    sw = 1'b0;
    hold(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
